dcsk_soft_demod: RTL and testbench
==================================

Name: dcsk_soft_demod

Overview:
- Parametrised successor to the hard-decision DCSK demodulator.
- Accepts one soft chip sample per qualified clock. Each transmitted bit is a reference burst of beta chips followed by a data burst of beta chips. Beta is run-time selectable up to MAX_BETA.
- Buffers the reference, correlates the data burst against it, slices the sign into one information bit, and packs bits into WORDLEN-bit words.
- Sits between the channel/ADC front end and the receive word sink. Also exports per-bit correlation for BER and soft-metric monitoring.

Parameters:
- SAMPLE_W, 4, chip sample width. Two's complement when >1. When =1: 1 means +1, 0 means -1 (legacy hard-chip mode).
- MAX_BETA, 16, largest spreading factor. Power of two, 2..256.
- WORDLEN, 32, information bits per output word.
- SEL_W, 2, Spread_Factor_Sel width. Must cover log2(MAX_BETA)-1.
- ACC_W, 2*SAMPLE_W+log2(MAX_BETA), correlator accumulator width (derived, not overridable).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-high reset.
- In_Sample  in  SAMPLE_W  received chip sample.
- In_Valid  in  1  In_Sample valid this cycle.
- Spread_Factor_Sel  in  SEL_W  beta = 2^(sel+1).
- Out_Data  out  WORDLEN  last completed word; bit 0 = first received bit.
- Out_Valid  out  1  one-cycle pulse, Out_Data updated.
- Bit_Corr  out  ACC_W  signed correlation of the last completed bit.
- Bit_Valid  out  1  one-cycle pulse per completed bit.

Behaviour:
- Reset: Rst asserted asynchronously forces state IDLE, chip and bit counters 0, Out_Data=0, Out_Valid=0, Bit_Corr=0, Bit_Valid=0. The reference buffer is not cleared.
- States:
  - IDLE: first In_Valid=1 cycle accepts chip 0 of a reference burst, go to REF.
  - REF: write ref[k]=sample for k=0..beta-1. After chip beta-1, go to DATA.
  - DATA: acc += ref[k]*sample (signed). After chip beta-1, slice the bit, then go to REF if the word is incomplete, else IDLE.
- Beta latch: Spread_Factor_Sel is sampled only on the cycle chip 0 of a reference burst is accepted. Changes mid-bit are ignored until the next bit. Beta may differ between bits of one word.
- Out-of-range sel: if 2^(sel+1) > MAX_BETA, beta = MAX_BETA.
- Acceptance: a chip is consumed only on cycles with In_Valid=1 in REF/DATA.
- Abort: In_Valid=0 while in REF or DATA → next state IDLE. Partial bit and partial word are discarded, bit index reset to 0, and no Out_Valid/Bit_Valid is issued. Out_Data holds its previous value.
- Accumulator: cleared when DATA is entered. Products are sign-extended to ACC_W, so there is no overflow for any legal input.
- Slicer: bit = 1 if final acc > 0, else 0 (tie → 0).
- Bit completion: registered, on the cycle after the last data chip is accepted.
  - Bit_Valid=1 for one cycle; Bit_Corr = final acc and holds until the next bit.
  - The bit is written at index bit_idx of the word shift register.
- Word completion: on the bit with index WORDLEN-1, in the same cycle as its Bit_Valid:
  - Out_Data = assembled word and Out_Valid=1 for one cycle.
  - bit_idx wraps to 0.
- Throughput: back-to-back bits with no dead cycles. Bit n+1 chip 0 may be accepted on the cycle bit n's Bit_Valid is high.
- Latency: 1 cycle from last data chip accepted to Bit_Valid/Out_Valid.
- Reset mid-operation: immediate return to the reset state; a word in progress is lost.

Test Plan:
- Reset: hold Rst with random In_Sample and In_Valid=1 → Out_Data=0, Out_Valid=0, Bit_Valid=0, Bit_Corr=0 throughout. Deassert Rst → IDLE, no spurious pulses.
- Beta=16 soft: SAMPLE_W=4, sel=3, word 0xA5A50F0F, chips ±7 continuous.
  - Each Bit_Corr = +784 for a 1 bit, -784 for a 0 bit.
  - Out_Valid pulses exactly once, 1 cycle after chip 1024, with Out_Data=0xA5A50F0F.
- Legacy hard mode: SAMPLE_W=1, sel=0 (beta 2), word 0x12345678 → Out_Valid at cycle 129 after the first chip, Out_Data=0x12345678, Bit_Corr ∈ {+2,-2}.
- Abort: In_Valid dropped at data chip 5 of bit 10 for 3 cycles, then a fresh word 0xDEADBEEF at sel=2 → no Out_Valid for the aborted word; next Out_Valid carries 0xDEADBEEF.
- Mid-bit sel change: bit starts at sel=3, sel→1 at reference chip 8 → that bit still consumes 32 chips; the following bit uses 8 chips; word decodes correctly.
- Boundaries:
  - Data chips all 0 → bit 0, Bit_Corr=0.
  - All ref=-8 and data=-8 at beta=16 → Bit_Corr=+1024, bit 1, no overflow.
  - sel=3 with MAX_BETA=8 → beta clamps to 8.

Source files
------------

// File: rtl/dcsk_soft_demod.sv
// Soft-decision DCSK demodulator.
// Each information bit is a reference burst of beta chips followed by a data burst of beta chips.
// The reference burst is buffered. The data burst is correlated against it, and the sign of the
// correlation gives one bit. Bits are packed LSB-first into WORDLEN-bit words.
//
// Ports:
//   Clk               rising-edge system clock
//   Rst               asynchronous active-high reset
//   In_Sample         chip sample; two's complement, or 1/0 = +1/-1 when SAMPLE_W == 1
//   In_Valid          In_Sample is valid; a low cycle mid-bit aborts the current word
//   Spread_Factor_Sel beta = 2^(sel+1), clamped to MAX_BETA, sampled at reference chip 0
//   Out_Data          last completed word, bit 0 = first received bit
//   Out_Valid         one-cycle pulse when Out_Data updates
//   Bit_Corr          signed correlation of the last completed bit
//   Bit_Valid         one-cycle pulse per completed bit
module dcsk_soft_demod #(
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned MAX_BETA = 16,
  parameter int unsigned WORDLEN  = 32,
  parameter int unsigned SEL_W    = 2,
  localparam int unsigned ACC_W   = 2 * SAMPLE_W + $clog2(MAX_BETA)
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [SAMPLE_W-1:0]     In_Sample,
  input  logic                    In_Valid,
  input  logic [SEL_W-1:0]        Spread_Factor_Sel,
  output logic [WORDLEN-1:0]      Out_Data,
  output logic                    Out_Valid,
  output logic signed [ACC_W-1:0] Bit_Corr,
  output logic                    Bit_Valid
);

  localparam int unsigned BetaLog = $clog2(MAX_BETA);
  localparam int unsigned IdxW    = (WORDLEN > 1) ? $clog2(WORDLEN) : 1;

  typedef enum logic [1:0] {StIdle, StRef, StData} state_e;

  state_e                  state_q, state_d;
  logic [BetaLog-1:0]      chip_q, chip_d;
  logic [BetaLog-1:0]      beta_last_q, beta_last_d;
  logic [BetaLog-1:0]      sel_last;
  logic [IdxW-1:0]         bit_idx_q, bit_idx_d;
  logic [WORDLEN-1:0]      word_q, word_d;
  logic [WORDLEN-1:0]      out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    bit_valid_q, bit_valid_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] bit_corr_q, bit_corr_d;
  logic signed [ACC_W-1:0] prod, acc_sum;
  logic                    bit_val;

  logic [SAMPLE_W-1:0]     ref_mem [MAX_BETA];
  logic                    ref_we;
  logic [BetaLog-1:0]      ref_waddr;

  // Map a raw chip onto a signed accumulator-width value.
  function automatic logic signed [ACC_W-1:0] chip_value(input logic [SAMPLE_W-1:0] s);
    logic signed [SAMPLE_W-1:0] s_s;
    s_s = s;
    if (SAMPLE_W == 1) begin
      return s[0] ? ACC_W'(1) : '1;
    end
    return ACC_W'(s_s);
  endfunction

  // Index of the last chip of a burst for the requested beta; beta >= MAX_BETA clamps to all ones.
  always_comb begin
    if (int'(Spread_Factor_Sel) + 1 >= BetaLog) begin
      sel_last = '1;
    end else begin
      sel_last = BetaLog'((32'd2 << Spread_Factor_Sel) - 32'd1);
    end
  end

  // Products fit the accumulator width, so truncating the multiply to ACC_W loses nothing.
  assign prod    = chip_value(ref_mem[chip_q]) * chip_value(In_Sample);
  assign acc_sum = acc_q + prod;
  assign bit_val = !acc_sum[ACC_W-1] && (acc_sum != '0);

  always_comb begin
    state_d     = state_q;
    chip_d      = chip_q;
    beta_last_d = beta_last_q;
    bit_idx_d   = bit_idx_q;
    word_d      = word_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    bit_corr_d  = bit_corr_q;
    bit_valid_d = 1'b0;
    ref_we      = 1'b0;
    ref_waddr   = chip_q;

    unique case (state_q)
      StIdle: begin
        if (In_Valid) begin
          ref_we      = 1'b1;
          ref_waddr   = '0;
          beta_last_d = sel_last;
          chip_d      = BetaLog'(1);
          state_d     = StRef;
        end
      end

      StRef: begin
        if (!In_Valid) begin
          state_d   = StIdle;
          chip_d    = '0;
          bit_idx_d = '0;
        end else begin
          ref_we = 1'b1;
          // Chip 0 here only follows a completed bit; it latches beta for the new bit.
          if (chip_q == '0) begin
            beta_last_d = sel_last;
          end
          if ((chip_q != '0) && (chip_q == beta_last_q)) begin
            state_d = StData;
            chip_d  = '0;
            acc_d   = '0;
          end else begin
            chip_d = chip_q + BetaLog'(1);
          end
        end
      end

      StData: begin
        if (!In_Valid) begin
          state_d   = StIdle;
          chip_d    = '0;
          bit_idx_d = '0;
        end else begin
          acc_d = acc_sum;
          if (chip_q == beta_last_q) begin
            bit_corr_d        = acc_sum;
            bit_valid_d       = 1'b1;
            word_d[bit_idx_q] = bit_val;
            chip_d            = '0;
            if (bit_idx_q == IdxW'(WORDLEN - 1)) begin
              out_data_d  = word_d;
              out_valid_d = 1'b1;
              bit_idx_d   = '0;
              state_d     = StIdle;
            end else begin
              bit_idx_d = bit_idx_q + IdxW'(1);
              state_d   = StRef;
            end
          end else begin
            chip_d = chip_q + BetaLog'(1);
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= StIdle;
      chip_q      <= '0;
      beta_last_q <= '1;
      bit_idx_q   <= '0;
      word_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      bit_corr_q  <= '0;
      bit_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_q      <= chip_d;
      beta_last_q <= beta_last_d;
      bit_idx_q   <= bit_idx_d;
      word_q      <= word_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      bit_corr_q  <= bit_corr_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  // Reference buffer keeps its contents across reset; every bit rewrites it before use.
  always_ff @(posedge Clk) begin
    if (ref_we) begin
      ref_mem[ref_waddr] <= In_Sample;
    end
  end

  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
  assign Bit_Corr  = bit_corr_q;
  assign Bit_Valid = bit_valid_q;

endmodule

// File: tb/tb_dcsk_soft_demod.sv
// Directed bench for dcsk_soft_demod: a 4-bit/beta-16 instance, a legacy 1-bit instance and a
// MAX_BETA=8 instance share clock, reset, sample and sel; In_Valid is routed to one at a time.
module tb_dcsk_soft_demod;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [3:0] samp;
  logic [1:0] sel;
  int         cur;
  logic [2:0] v;

  always #5 clk = ~clk;

  assign v[0] = vld && (cur == 0);
  assign v[1] = vld && (cur == 1);
  assign v[2] = vld && (cur == 2);

  logic [31:0] od0; logic ov0; logic [11:0] bc0; logic bv0;
  logic [31:0] od1; logic ov1; logic [5:0]  bc1; logic bv1;
  logic [3:0]  od2; logic ov2; logic [10:0] bc2; logic bv2;

  dcsk_soft_demod #(.SAMPLE_W(4), .MAX_BETA(16), .WORDLEN(32), .SEL_W(2)) u_main (
    .Clk(clk), .Rst(rst), .In_Sample(samp), .In_Valid(v[0]), .Spread_Factor_Sel(sel),
    .Out_Data(od0), .Out_Valid(ov0), .Bit_Corr(bc0), .Bit_Valid(bv0)
  );

  dcsk_soft_demod #(.SAMPLE_W(1), .MAX_BETA(16), .WORDLEN(32), .SEL_W(2)) u_legacy (
    .Clk(clk), .Rst(rst), .In_Sample(samp[0:0]), .In_Valid(v[1]), .Spread_Factor_Sel(sel),
    .Out_Data(od1), .Out_Valid(ov1), .Bit_Corr(bc1), .Bit_Valid(bv1)
  );

  dcsk_soft_demod #(.SAMPLE_W(4), .MAX_BETA(8), .WORDLEN(4), .SEL_W(2)) u_clamp (
    .Clk(clk), .Rst(rst), .In_Sample(samp), .In_Valid(v[2]), .Spread_Factor_Sel(sel),
    .Out_Data(od2), .Out_Valid(ov2), .Bit_Corr(bc2), .Bit_Valid(bv2)
  );

  int          cyc = 0;
  int          ov_cnt [3] = '{0, 0, 0};
  logic [31:0] ov_data [3] = '{32'd0, 32'd0, 32'd0};
  int          ov_cyc [3] = '{0, 0, 0};
  int          corr_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bv0) corr_q.push_back(int'($signed(bc0)));
    if (bv1) corr_q.push_back(int'($signed(bc1)));
    if (bv2) corr_q.push_back(int'($signed(bc2)));
    if (ov0) begin ov_cnt[0]++; ov_data[0] = od0; ov_cyc[0] = cyc; end
    if (ov1) begin ov_cnt[1]++; ov_data[1] = od1; ov_cyc[1] = cyc; end
    if (ov2) begin ov_cnt[2]++; ov_data[2] = 32'(od2); ov_cyc[2] = cyc; end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chip(input int s);
    samp = 4'(s);
    vld  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // sw_at: reference chip index at which sel switches to sw_sel (-1 = never).
  task automatic send_bit(input int r, input int d, input int beta, input int sw_at,
                          input logic [1:0] sw_sel);
    for (int k = 0; k < beta; k++) begin
      if (k == sw_at) sel = sw_sel;
      chip(r);
    end
    for (int k = 0; k < beta; k++) chip(d);
  endtask

  task automatic send_word(input logic [31:0] w, input int n, input int beta, input int r,
                           input int one, input int zero);
    for (int i = 0; i < n; i++) send_bit(r, w[i] ? one : zero, beta, -1, 2'd0);
  endtask

  task automatic idle(input int n);
    vld = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int          t0;
  logic [31:0] w;

  initial begin
    rst  = 1'b1;
    vld  = 1'b1;
    sel  = 2'd3;
    cur  = 0;
    samp = '0;

    // Reset held with live input.
    repeat (4) begin
      @(posedge clk);
      #1 samp = 4'($urandom);
      @(negedge clk);
      check("rst_out_data", od0, 0);
      check("rst_out_valid", ov0, 0);
      check("rst_bit_valid", bv0, 0);
      check("rst_bit_corr", bc0, 0);
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    rst = 1'b0;
    idle(3);
    check("post_rst_no_ov", ov_cnt[0], 0);
    check("post_rst_no_bv", corr_q.size(), 0);

    // Beta 16, +/-7 chips: |corr| = 7*7*16 = 784.
    sel = 2'd3;
    w   = 32'hA5A5_0F0F;
    t0  = cyc;
    send_word(w, 32, 16, 7, 7, -7);
    idle(2);
    check("b16_ov_count", ov_cnt[0], 1);
    check("b16_word", ov_data[0], 32'hA5A5_0F0F);
    check("b16_latency", ov_cyc[0], t0 + 1024);
    check("b16_nbits", corr_q.size(), 32);
    for (int i = 0; i < 32; i++) check("b16_corr", corr_q[i], w[i] ? 784 : -784);
    corr_q.delete();

    // Zero data chips tie to 0; -8*-8*16 = +1024 fits the accumulator.
    w  = 32'h5A5A_C3C2;
    send_bit(7, 0, 16, -1, 2'd0);
    send_bit(-8, -8, 16, -1, 2'd0);
    send_word(w >> 2, 30, 16, 7, 7, -7);
    idle(2);
    check("tie_corr", corr_q[0], 0);
    check("max_corr", corr_q[1], 1024);
    check("bound_ov_count", ov_cnt[0], 2);
    check("bound_word", ov_data[0], 32'h5A5A_C3C2);
    corr_q.delete();

    // Abort in data chip 5 of bit 10, then a full word at beta 8 (|corr| = 5*5*8 = 200).
    send_word(32'hFFFF_FFFF, 10, 16, 7, 7, -7);
    for (int k = 0; k < 16; k++) chip(7);
    for (int k = 0; k < 5; k++) chip(7);
    idle(3);
    check("abort_no_ov", ov_cnt[0], 2);
    sel = 2'd2;
    w   = 32'hDEAD_BEEF;
    t0  = cyc;
    send_word(w, 32, 8, 5, 5, -5);
    idle(2);
    check("abort_ov_count", ov_cnt[0], 3);
    check("abort_word", ov_data[0], 32'hDEAD_BEEF);
    check("abort_latency", ov_cyc[0], t0 + 512);
    check("abort_nbits", corr_q.size(), 42);
    check("abort_corr", corr_q[10], 200);
    corr_q.delete();

    // sel drops to 1 at reference chip 8: bit 0 stays 32 chips, the rest take 8.
    sel = 2'd3;
    w   = 32'h3C96_A5E1;
    t0  = cyc;
    send_bit(6, 6, 16, 8, 2'd1);
    send_word(w >> 1, 31, 4, 6, 6, -6);
    idle(2);
    check("sel_ov_count", ov_cnt[0], 4);
    check("sel_word", ov_data[0], 32'h3C96_A5E1);
    check("sel_latency", ov_cyc[0], t0 + 280);
    check("sel_corr0", corr_q[0], 576);
    check("sel_corr1", corr_q[1], -144);
    corr_q.delete();

    // Legacy 1-bit chips at beta 2: 1 = +1, 0 = -1.
    cur = 1;
    sel = 2'd0;
    w   = 32'h1234_5678;
    t0  = cyc;
    send_word(w, 32, 2, 1, 1, 0);
    idle(2);
    check("leg_ov_count", ov_cnt[1], 1);
    check("leg_word", ov_data[1], 32'h1234_5678);
    check("leg_latency", ov_cyc[1], t0 + 128);
    check("leg_corr0", corr_q[0], -2);
    check("leg_corr3", corr_q[3], 2);
    corr_q.delete();

    // MAX_BETA=8 with sel=3 clamps to beta 8 (|corr| = 3*3*8 = 72).
    cur = 2;
    sel = 2'd3;
    t0  = cyc;
    send_word(32'h0000_000A, 4, 8, 3, 3, -3);
    idle(2);
    check("clamp_ov_count", ov_cnt[2], 1);
    check("clamp_word", ov_data[2], 32'h0000_000A);
    check("clamp_latency", ov_cyc[2], t0 + 64);
    check("clamp_corr0", corr_q[0], -72);
    check("clamp_corr1", corr_q[1], 72);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
